// File: rtl/acq_ctrl.sv
// acq_ctrl: code-acquisition and lock controller for the DSSS receive path.
//
// A free-running time base counts one symbol (CHIP_CLKS * CODE_LEN clocks). The last count is
// the decision cycle. At that cycle the correlator energy is compared against the threshold.
// The result steps the local code phase through a serial search, confirms a hit over further
// dwells, and then tracks loss of lock.
//
// Ports:
//   clk, rst_n     - clock; synchronous active-low reset
//   start, stop    - begin acquisition from idle / force idle from any state
//   threshold      - unsigned hit threshold, sampled at each decision
//   corr_energy    - correlator accumulator output
//   code_phase     - chip offset for the local m-code generator (0..CODE_LEN-1)
//   dwell_cnt      - time-base position within the symbol
//   corr_clr       - accumulator load strobe at dwell start (not in idle)
//   searching      - high in arm, search and verify
//   flag           - lock indicator
//   sym_strobe     - one-cycle pulse at each symbol boundary while locked
//   search_fail    - one-cycle pulse after CODE_LEN consecutive search misses
module acq_ctrl #(
  parameter int unsigned CHIP_CLKS = 16,
  parameter int unsigned CODE_LEN  = 31,
  parameter int unsigned E_W       = 16,
  parameter int unsigned VERIFY_N  = 2,
  parameter int unsigned LOSS_MAX  = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           stop,
  input  logic [E_W-1:0] threshold,
  input  logic [E_W-1:0] corr_energy,
  output logic [4:0]     code_phase,
  output logic [8:0]     dwell_cnt,
  output logic           corr_clr,
  output logic           searching,
  output logic           flag,
  output logic           sym_strobe,
  output logic           search_fail
);

  localparam int unsigned Dwell = CHIP_CLKS * CODE_LEN;
  localparam int unsigned VcntW = ($clog2(VERIFY_N + 1) > 0) ? $clog2(VERIFY_N + 1) : 1;
  localparam int unsigned LossW = ($clog2(LOSS_MAX + 1) > 0) ? $clog2(LOSS_MAX + 1) : 1;

  typedef enum logic [2:0] {StIdle, StArm, StSearch, StVerify, StLock} state_e;

  state_e           state_q, state_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [4:0]       phase_q, phase_d;
  logic [4:0]       miss_q, miss_d;
  logic [VcntW-1:0] vcnt_q, vcnt_d;
  logic [LossW-1:0] loss_q, loss_d;
  logic             searching_q, searching_d;
  logic             flag_q, flag_d;
  logic             sym_q, sym_d;
  logic             fail_q, fail_d;

  logic       is_dec;
  logic       hit;
  logic [4:0] next_phase;

  assign is_dec     = (cnt_q == 9'(Dwell - 1));
  assign hit        = (corr_energy >= threshold);
  assign next_phase = (phase_q == 5'(CODE_LEN - 1)) ? 5'd0 : phase_q + 5'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = is_dec ? 9'd0 : cnt_q + 9'd1;
    phase_d = phase_q;
    miss_d  = miss_q;
    vcnt_d  = vcnt_q;
    loss_d  = loss_q;
    sym_d   = 1'b0;
    fail_d  = 1'b0;

    if (stop) begin
      // Phase is kept so a restart resumes from the last tried offset.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StArm;
            miss_d  = '0;
            vcnt_d  = '0;
            loss_d  = '0;
          end
        end
        // The first dwell is partial, so its decision is discarded.
        StArm: begin
          if (is_dec) state_d = StSearch;
        end
        StSearch: begin
          if (is_dec) begin
            if (hit) begin
              state_d = StVerify;
              vcnt_d  = '0;
              miss_d  = '0;
            end else begin
              phase_d = next_phase;
              if (miss_q == 5'(CODE_LEN - 1)) begin
                miss_d = '0;
                fail_d = 1'b1;
              end else begin
                miss_d = miss_q + 5'd1;
              end
            end
          end
        end
        StVerify: begin
          if (is_dec) begin
            if (hit) begin
              if (vcnt_q >= VcntW'(VERIFY_N - 1)) begin
                state_d = StLock;
                vcnt_d  = VcntW'(VERIFY_N);
                loss_d  = '0;
              end else begin
                vcnt_d = vcnt_q + VcntW'(1);
              end
            end else begin
              state_d = StSearch;
              phase_d = next_phase;
            end
          end
        end
        StLock: begin
          if (is_dec) begin
            sym_d = 1'b1;
            if (hit) begin
              loss_d = '0;
            end else if (loss_q >= LossW'(LOSS_MAX - 1)) begin
              // Re-search starts at the phase that was locked.
              state_d = StSearch;
              loss_d  = '0;
              miss_d  = '0;
            end else begin
              loss_d = loss_q + LossW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    searching_d = (state_d == StArm) || (state_d == StSearch) || (state_d == StVerify);
    flag_d      = (state_d == StLock);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      phase_q     <= '0;
      miss_q      <= '0;
      vcnt_q      <= '0;
      loss_q      <= '0;
      searching_q <= 1'b0;
      flag_q      <= 1'b0;
      sym_q       <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      miss_q      <= miss_d;
      vcnt_q      <= vcnt_d;
      loss_q      <= loss_d;
      searching_q <= searching_d;
      flag_q      <= flag_d;
      sym_q       <= sym_d;
      fail_q      <= fail_d;
    end
  end

  assign code_phase  = phase_q;
  assign dwell_cnt   = cnt_q;
  assign corr_clr    = (cnt_q == 9'd0) && (state_q != StIdle);
  assign searching   = searching_q;
  assign flag        = flag_q;
  assign sym_strobe  = sym_q;
  assign search_fail = fail_q;

endmodule

// File: doc/acq_ctrl.md
# acq_ctrl

Code-acquisition and lock controller for the DSSS receive path. It runs a free time base aligned to the 496-clock symbol (31 chips × 16 clocks). It steps the local m-code phase across all 31 chip offsets, judges each one-symbol dwell by comparing the correlator energy against a threshold, and confirms a hit over further dwells before declaring lock. After lock it tracks loss and restarts the search when needed. It sits between the m-code generator / correlator pair and the `top`-level `flag` output.

## Interface
Parameters:
- `CHIP_CLKS`, 16: clocks per chip.
- `CODE_LEN`, 31: chips per code period; also the number of code phases.
- `E_W`, 16: width of the energy and threshold values.
- `VERIFY_N`, 2: consecutive hit dwells required after the first hit to declare lock.
- `LOSS_MAX`, 3: consecutive miss dwells in LOCK that drop lock.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset. One clock; reset is synchronous and active-low.
- `start`, input, 1: level or pulse; begins acquisition when in IDLE.
- `stop`, input, 1: forces IDLE from any state.
- `threshold`, input, `E_W`: unsigned hit threshold, sampled live at each decision.
- `corr_energy`, input, `E_W`: unsigned registered accumulator output of the correlator.
- `code_phase`, output, 5: chip offset applied to the local m-code generator, range 0..30.
- `dwell_cnt`, output, 9: time-base position, range 0..DWELL-1.
- `corr_clr`, output, 1: accumulator load-instead-of-add strobe.
- `searching`, output, 1: high in ARM, SEARCH and VERIFY.
- `flag`, output, 1: lock indicator.
- `sym_strobe`, output, 1: 1-cycle pulse at each symbol boundary while locked.
- `search_fail`, output, 1: 1-cycle pulse after 31 consecutive misses in SEARCH.

## Operation
- DWELL = `CHIP_CLKS`×`CODE_LEN` = 496.
- `dwell_cnt` counts 0→495→0 continuously while `rst_n` is high, independent of state. Count 495 is the decision cycle (D). Count 0 is the dwell start.
- `corr_clr` = (`dwell_cnt`==0) and state ≠ IDLE.
- The correlator must present, at D, the energy of samples 0..494 of the current dwell. The sample taken at D is excluded from the decision.
- Hit = `corr_energy` ≥ `threshold` (unsigned compare), evaluated only at D.
- State machine:
  - IDLE: `start` and not `stop` → ARM.
  - ARM: at D → SEARCH. No decision is made at this D; it discards the partial first dwell.
  - SEARCH, at D:
    - hit → VERIFY, with the verify count cleared.
    - miss → `code_phase` advances by 1, wrapping 30→0. The miss count increments. When the miss count reaches 31, `search_fail` pulses and the miss count clears. Search continues.
  - VERIFY, at D:
    - hit → the verify count increments. When it equals `VERIFY_N`, go to LOCK.
    - miss → SEARCH, with `code_phase` advanced by 1.
  - LOCK, at D:
    - `sym_strobe` pulses.
    - hit → the loss count clears.
    - miss → the loss count increments. When it reaches `LOSS_MAX`, go to SEARCH with `code_phase` unchanged and the miss count cleared.
  - `stop` from any state → IDLE at the next edge. The current `code_phase` is retained.
- All state changes and `code_phase` updates occur on the D edge, so the new phase is valid from count 0 of the next dwell.
- Miss count is 5 bits. Verify and loss counters saturate at their limits.
- Priority: `stop` > `start` > decision. `start` outside IDLE is ignored.

## Timing
- Reset, with `rst_n` low at a clock edge, gives:
  - state IDLE;
  - `dwell_cnt`=0, `code_phase`=0;
  - `corr_clr`=0, `flag`=0, `searching`=0, `sym_strobe`=0, `search_fail`=0;
  - all internal counters at 0.
- Reset mid-dwell restarts the time base at 0 on the first cycle with `rst_n` high.
- `start` sampled high at edge T gives state ARM from T+1. The first SEARCH dwell starts at the next count 0.
- Start-to-lock latency with a hit at phase p, counted from the first SEARCH dwell, is (p + 1 + `VERIFY_N`) dwells. With the defaults this is 496×(p+3) clocks.
- Outputs:
  - `flag` is high exactly while state is LOCK.
  - `flag` rises the cycle after the final verify D.
  - `flag` falls the cycle after the `LOSS_MAX`-th miss D.
- `sym_strobe` and `search_fail` are registered 1-cycle pulses, asserted in the cycle after D, that is at count 0.
- `searching`, `flag` and `code_phase` are registered. There is no input→output combinational path except through registers. `corr_clr` is decoded from registered state.

## Test plan
- **Reset behaviour.** Hold `rst_n`=0 for 3 cycles with `start`=1. Required: all outputs 0, and `dwell_cnt` 0,1,2… after release. Then ARM, then the first `corr_clr` at `dwell_cnt`=0 while in SEARCH.
- **Acquisition.** Model the energy as 4000 when `code_phase`==7, else 200; `threshold`=1000. Required: phases 0..7 each held for 496 clocks, then 2 verify dwells at phase 7, and `flag`=1 at 496×10 clocks after the first SEARCH dwell start.
- **No signal.** Energy is always 0. Required: `code_phase` wraps 30→0, `search_fail` pulses once every 31×496 clocks, and `flag` stays 0.
- **Verify reject.** Hit at phase 4, then a miss on the first verify dwell. Required: return to SEARCH with `code_phase`=5, and `flag` never rises.
- **Loss of lock.** From LOCK at phase 7, apply miss, hit, miss, miss, miss. Required: `flag` drops only after the 3rd consecutive miss, the next state is SEARCH at phase 7, and `sym_strobe` occurs once per 496 clocks while locked.
- **Stop mid-VERIFY.** Assert `stop` and `start` in the same cycle during VERIFY. Required: IDLE next cycle, `corr_clr` silent, and `code_phase` held.
